// File: rtl/inpfifo_drain_sched_pkg.sv
// Shared types and constants for the inpfifo drain scheduler.
// Provides frame tags, channel index width and the FSM state type.
package inpfifo_pkg;

   localparam logic [7:0] HDR_TAG = 8'hA5;
   localparam logic [3:0] TRL_TAG = 4'hE;
   localparam int         CH_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA,
      TRL
   } state_t;

endpackage

// File: rtl/inpfifo_drain_sched_if.sv
// Packet output stream: 16-bit data with valid/ready handshake.
// master drives out_data/out_valid and samples out_ready.
interface inpfifo_drain_sched_if;

   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/inpfifo_drain_sched_rr_arbiter.sv
// Combinational round-robin pick of the first request at or after ptr.
// Ports: req (per channel), ptr (start index) -> gnt (one-hot), gnt_idx.
module rr_arbiter
   import inpfifo_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]  req,
   input  logic [CH_W-1:0] ptr,
   output logic [NCH-1:0]  gnt,
   output logic [CH_W-1:0] gnt_idx
);

   localparam logic [CH_W:0] NCH_W = (CH_W+1)'(NCH);

   logic [2*NCH-1:0] req2;
   logic [NCH-1:0]   rot;
   logic [CH_W-1:0]  first;
   logic [CH_W:0]    sum;
   logic             found;

   // Rotate so that ptr sits at bit 0, then take the lowest set bit.
   always_comb begin
      req2  = {req, req} >> ptr;
      rot   = req2[NCH-1:0];
      first = '0;
      found = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            first = CH_W'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, first};
      if (sum >= NCH_W) begin
         sum = sum - NCH_W;
      end
      gnt_idx = sum[CH_W-1:0];
      gnt     = found ? (NCH'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/inpfifo_drain_sched.sv
// Round-robin drain of NCH channel FIFOs into framed packets (hdr/data/trl).
// Ports: clk, rst, en, fifo_empty/full/Q, fifo_rd, out_if, ovf_sticky, ovf_clr, busy.
module inpfifo_drain_sched
   import inpfifo_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int BURST = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NCH-1:0]       fifo_empty,
   input  logic [NCH-1:0]       fifo_full,
   input  logic [16*NCH-1:0]    fifo_Q,
   output logic [NCH-1:0]       fifo_rd,
   inpfifo_drain_sched_if.master out_if,
   output logic [NCH-1:0]       ovf_sticky,
   input  logic                 ovf_clr,
   output logic                 busy
);

   localparam logic [7:0]    BURST_W = 8'(BURST);
   localparam logic [CH_W:0] NCH_W   = (CH_W+1)'(NCH);

   state_t          state, state_nxt;
   logic [CH_W-1:0] ptr, ch, gnt_idx;
   logic [NCH-1:0]  ch_oh, gnt, ovf_nxt;
   logic [7:0]      words;
   logic            hdr_ovf;
   logic [15:0]     s0, s1, q_ch, head;
   logic [1:0]      cnt;
   logic            inflight;
   logic            empty_ch, skid_valid, rd;
   logic            pop, pop_skid, push;
   logic [2:0]      occ;
   logic [CH_W:0]   ch_inc;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req     (~fifo_empty),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      q_ch = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_oh[k]) begin
            q_ch = fifo_Q[16*k +: 16];
         end
      end
   end

   assign ovf_nxt    = (ovf_sticky & ~{NCH{ovf_clr}}) | fifo_full;
   assign empty_ch   = |(fifo_empty & ch_oh);
   // An in-flight word is shown straight from fifo_Q, so an empty skid
   // does not cost a bubble; it is captured only if not taken at once.
   assign skid_valid = (cnt != 2'd0) || inflight;
   assign head       = (cnt != 2'd0) ? s0 : q_ch;
   assign occ        = {1'b0, cnt} + {2'b00, inflight};
   assign rd         = (state == DATA) && !empty_ch &&
                       (words < BURST_W) && (occ < 3'd2);
   assign fifo_rd    = rd ? ch_oh : '0;
   assign busy       = (state != IDLE);
   assign pop        = out_if.out_valid && out_if.out_ready && skid_valid &&
                       ((state == DATA) || (state == TRL));
   assign pop_skid   = pop && (cnt != 2'd0);
   assign push       = inflight && !(pop && (cnt == 2'd0));
   assign ch_inc     = {1'b0, ch} + (CH_W+1)'(1);

   always_comb begin
      state_nxt        = state;
      out_if.out_valid = 1'b0;
      out_if.out_data  = '0;
      unique case (state)
         IDLE: begin
            if (en && (gnt != '0)) begin
               state_nxt = HDR;
            end
         end
         HDR: begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = {HDR_TAG, hdr_ovf, 3'b000, ch};
            if (out_if.out_ready) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            out_if.out_valid = skid_valid;
            out_if.out_data  = skid_valid ? head : '0;
            if (((words == BURST_W) || empty_ch) && !inflight) begin
               state_nxt = TRL;
            end
         end
         TRL: begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = skid_valid ? head : {TRL_TAG, ch, words};
            if (out_if.out_ready && !skid_valid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         ch         <= '0;
         ch_oh      <= '0;
         words      <= '0;
         hdr_ovf    <= 1'b0;
         s0         <= '0;
         s1         <= '0;
         cnt        <= '0;
         inflight   <= 1'b0;
         ovf_sticky <= '0;
      end else begin
         state      <= state_nxt;
         inflight   <= rd;
         ovf_sticky <= ovf_nxt;
         if ((state == IDLE) && (state_nxt == HDR)) begin
            ch      <= gnt_idx;
            ch_oh   <= gnt;
            hdr_ovf <= |(ovf_nxt & gnt);
            words   <= '0;
         end else if (rd) begin
            words <= words + 8'd1;
         end
         if ((state == TRL) && (state_nxt == IDLE)) begin
            ptr <= (ch_inc == NCH_W) ? '0 : ch_inc[CH_W-1:0];
         end
         unique case ({pop_skid, push})
            2'b10: begin
               s0  <= s1;
               cnt <= cnt - 2'd1;
            end
            2'b01: begin
               if (cnt == 2'd0) s0 <= q_ch;
               else             s1 <= q_ch;
               cnt <= cnt + 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  s0 <= q_ch;
               end else begin
                  s0 <= s1;
                  s1 <= q_ch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inpfifo_drain_sched.sv
// Scoreboard bench for inpfifo_drain_sched (NCH=4, BURST=4).
// Directed packets per channel; a monitor pops expected words on transfer.
module tb_inpfifo_drain_sched;

   localparam int NCH   = 4;
   localparam int BURST = 4;

   typedef struct {
      logic [15:0] d;
      bit          is_data;
   } exp_t;

   logic              clk        = 1'b0;
   logic              rst        = 1'b1;
   logic              en         = 1'b0;
   logic              ovf_clr    = 1'b0;
   logic              busy;
   logic [NCH-1:0]    fifo_empty = '1;
   logic [NCH-1:0]    fifo_full  = '0;
   logic [NCH-1:0]    fifo_rd;
   logic [NCH-1:0]    ovf_sticky;
   logic [16*NCH-1:0] fifo_q     = '0;

   inpfifo_drain_sched_if s_if ();

   exp_t        exp_q[$];
   logic [15:0] fq[NCH][$];
   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   int          dx_cnt = 0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   always #5 clk = ~clk;

   inpfifo_drain_sched #(.NCH(NCH), .BURST(BURST)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_Q     (fifo_q),
      .fifo_rd    (fifo_rd),
      .out_if     (s_if.master),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr),
      .busy       (busy)
   );

   // Channel FIFO models: 1-cycle read latency, empty flag follows the queue.
   always @(posedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (fifo_rd[k]) begin
            checks++;
            if (fq[k].size() == 0) begin
               errors++;
               $display("FAIL rd_empty: ch%0d read while empty, required no read", k);
            end else begin
               fifo_q[16*k +: 16] <= fq[k].pop_front();
            end
         end
      end
      for (int k = 0; k < NCH; k++) begin
         fifo_empty[k] <= (fq[k].size() == 0);
      end
   end

   // Monitor: sampled mid-cycle, ahead of the edge that completes a transfer.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         rd_cnt     = 0;
         dx_cnt     = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!(s_if.out_valid && s_if.out_data == prev_data)) begin
               errors++;
               $display("FAIL stall_stable: got valid=%0b data=%h, required valid=1 data=%h",
                        s_if.out_valid, s_if.out_data, prev_data);
            end
         end
         if (fifo_rd != '0) begin
            checks++;
            if (!$onehot(fifo_rd) || (rd_cnt - dx_cnt) >= 2) begin
               errors++;
               $display("FAIL rd_gate: got rd=%b with %0d words held, required one-hot and <2",
                        fifo_rd, rd_cnt - dx_cnt);
            end
            rd_cnt++;
         end
         if (s_if.out_valid && s_if.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stream: got %h, required no output", s_if.out_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (s_if.out_data !== e.d) begin
                  errors++;
                  $display("FAIL stream: got %h, required %h", s_if.out_data, e.d);
               end
               if (e.is_data) dx_cnt++;
            end
         end
         prev_stall = s_if.out_valid && !s_if.out_ready;
         prev_data  = s_if.out_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic fill(input int k, input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) fq[k].push_back(base + 16'(i));
   endtask

   task automatic expect_pkt(input int k, input bit ovf,
                             input logic [15:0] base, input int n);
      exp_t e;
      e.d = {8'hA5, ovf, 3'b000, 4'(k)};
      e.is_data = 1'b0;
      exp_q.push_back(e);
      for (int i = 0; i < n; i++) begin
         e.d = base + 16'(i);
         e.is_data = 1'b1;
         exp_q.push_back(e);
      end
      e.d = {4'hE, 4'(k), 8'(n)};
      e.is_data = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name, input bit rnd);
      int n = 0;
      tick();
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         if (rnd) s_if.out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      s_if.out_ready = 1'b1;
      checks++;
      if (n >= 500) begin
         errors++;
         $display("FAIL %s: timeout with %0d words outstanding, required 0",
                  name, exp_q.size());
      end
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!busy && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!busy) begin
         errors++;
         $display("FAIL %s: got busy=0 after 50 clks, required 1", name);
      end
   endtask

   task automatic flush_all();
      exp_q.delete();
      for (int k = 0; k < NCH; k++) fq[k].delete();
   endtask

   initial begin
      s_if.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_valid", 32'(s_if.out_valid), 32'h0);
      check("rst_data", 32'(s_if.out_data), 32'h0);
      check("rst_rd", 32'(fifo_rd), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ovf", 32'(ovf_sticky), 32'h0);
      en = 1'b1;

      fill(0, 16'h0001, 3);
      expect_pkt(0, 1'b0, 16'h0001, 3);
      wait_done("single_ch0", 1'b0);

      fill(0, 16'h0010, 1);
      fill(1, 16'h0011, 1);
      expect_pkt(1, 1'b0, 16'h0011, 1);
      expect_pkt(0, 1'b0, 16'h0010, 1);
      wait_done("ptr_after_ch0", 1'b0);

      rst = 1'b1;
      flush_all();
      tick();
      tick();
      rst = 1'b0;
      tick();

      fill(0, 16'h0100, 8);
      fill(1, 16'h0200, 4);
      fill(2, 16'h0300, 4);
      fill(3, 16'h0400, 4);
      expect_pkt(0, 1'b0, 16'h0100, 4);
      expect_pkt(1, 1'b0, 16'h0200, 4);
      expect_pkt(2, 1'b0, 16'h0300, 4);
      expect_pkt(3, 1'b0, 16'h0400, 4);
      expect_pkt(0, 1'b0, 16'h0104, 4);
      wait_done("rr_burst", 1'b0);

      fill(1, 16'h3000, 4);
      expect_pkt(1, 1'b0, 16'h3000, 4);
      wait_done("rand_ready", 1'b1);

      fifo_full = 4'b0100;
      tick();
      fifo_full = '0;
      check("ovf_set", 32'(ovf_sticky), 32'h4);
      fill(2, 16'h4000, 2);
      expect_pkt(2, 1'b1, 16'h4000, 2);
      wait_done("ovf_hdr", 1'b0);
      check("ovf_hold", 32'(ovf_sticky), 32'h4);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(ovf_sticky), 32'h0);
      fifo_full = 4'b0100;
      ovf_clr = 1'b1;
      tick();
      fifo_full = '0;
      ovf_clr = 1'b0;
      check("ovf_set_wins", 32'(ovf_sticky), 32'h4);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr2", 32'(ovf_sticky), 32'h0);

      fill(1, 16'h5000, 4);
      fill(2, 16'h6000, 2);
      expect_pkt(1, 1'b0, 16'h5000, 4);
      wait_busy("en_grant");
      tick();
      tick();
      en = 1'b0;
      wait_done("en_off_finish", 1'b0);
      repeat (10) tick();
      check("en_off_busy", 32'(busy), 32'h0);
      check("en_off_valid", 32'(s_if.out_valid), 32'h0);
      expect_pkt(2, 1'b0, 16'h6000, 2);
      en = 1'b1;
      wait_done("en_resume", 1'b0);

      fill(3, 16'h7300, 4);
      expect_pkt(3, 1'b0, 16'h7300, 4);
      wait_busy("rst_grant");
      tick();
      tick();
      rst = 1'b1;
      flush_all();
      #1;
      check("midrst_rd", 32'(fifo_rd), 32'h0);
      check("midrst_valid", 32'(s_if.out_valid), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      fill(3, 16'h7310, 1);
      fill(0, 16'h7000, 1);
      expect_pkt(0, 1'b0, 16'h7000, 1);
      expect_pkt(3, 1'b0, 16'h7310, 1);
      wait_done("after_rst", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
